// File: rtl/clk_en_sched.sv
// rtl/clk_en_sched.sv - clock-enable tick scheduler with programmable divide ratio
// Emits a one-cycle tick every cfg_div+1 cycles plus a 50% square wave; ratio changes take effect at period boundaries.
module clk_en_sched #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             tick,
   output logic             clk_div,
   output logic             active,
   output logic             pending
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cur_div;
   logic [CNT_W-1:0] shadow;
   logic             cfg_accept;
   logic             wrap;

   assign cfg_ready  = (state != PEND);
   assign active     = (state != IDLE);
   assign pending    = (state == PEND);
   assign cfg_accept = cfg_valid && cfg_ready;
   assign wrap       = (cnt == cur_div);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         cur_div <= '0;
         shadow  <= '0;
         tick    <= 1'b0;
         clk_div <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt     <= '0;
               tick    <= 1'b0;
               clk_div <= 1'b0;
               if (cfg_accept)
                  cur_div <= cfg_div;
               if (ena)
                  state <= RUN;
            end
            RUN: begin
               if (!ena) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  tick    <= 1'b0;
                  clk_div <= 1'b0;
                  // A ratio offered while stopping is kept rather than dropped.
                  if (cfg_accept)
                     cur_div <= cfg_div;
               end else begin
                  if (wrap) begin
                     cnt     <= '0;
                     tick    <= 1'b1;
                     clk_div <= ~clk_div;
                  end else begin
                     cnt  <= cnt + 1'b1;
                     tick <= 1'b0;
                  end
                  if (cfg_accept) begin
                     shadow <= cfg_div;
                     state  <= PEND;
                  end
               end
            end
            PEND: begin
               if (!ena) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  tick    <= 1'b0;
                  clk_div <= 1'b0;
                  cur_div <= shadow;
               end else if (wrap) begin
                  // Swap in the queued ratio only on a period boundary.
                  cnt     <= '0;
                  tick    <= 1'b1;
                  clk_div <= ~clk_div;
                  cur_div <= shadow;
                  state   <= RUN;
               end else begin
                  cnt  <= cnt + 1'b1;
                  tick <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               tick    <= 1'b0;
               clk_div <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_en_sched.sv
// tb/tb_clk_en_sched.sv - self-checking bench for clk_en_sched
// Reference model tracks absolute tick times and a queued period length.
module tb_clk_en_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       ena;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       tick;
   logic       clk_div;
   logic       active;
   logic       pending;

   int checks = 0;
   int errors = 0;

   // reference model state
   int n        = 0;
   bit m_run    = 0;
   bit m_has_q  = 0;
   int m_per    = 1;
   int m_q      = 0;
   int m_next   = 0;
   bit m_tick   = 0;
   bit m_cd     = 0;

   clk_en_sched #(.CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .ena       (ena),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .tick      (tick),
      .clk_div   (clk_div),
      .active    (active),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp_v);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit v, input int d);
      bit acc;
      n++;
      if (r) begin
         m_run = 0; m_has_q = 0; m_per = 1; m_q = 0; m_tick = 0; m_cd = 0;
      end else if (!m_run) begin
         if (v) m_per = d + 1;
         if (e) begin
            m_run  = 1;
            m_next = n + m_per;
         end
         m_tick = 0; m_cd = 0;
      end else if (!e) begin
         if (m_has_q) m_per = m_q + 1;
         else if (v) m_per = d + 1;
         m_has_q = 0; m_run = 0; m_tick = 0; m_cd = 0;
      end else begin
         acc = v && !m_has_q;
         if (n == m_next) begin
            m_tick = 1;
            m_cd   = ~m_cd;
            if (m_has_q) begin
               m_per   = m_q + 1;
               m_has_q = 0;
            end
            m_next = n + m_per;
         end else begin
            m_tick = 0;
         end
         if (acc) begin
            m_q     = d;
            m_has_q = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit v, input int d);
      reset     = r;
      ena       = e;
      cfg_valid = v;
      cfg_div   = d[7:0];
      @(posedge clk);
      model_edge(r, e, v, d);
      #1;
      chk("tick",      {31'd0, tick},      {31'd0, m_tick});
      chk("clk_div",   {31'd0, clk_div},   {31'd0, m_cd});
      chk("active",    {31'd0, active},    {31'd0, m_run});
      chk("pending",   {31'd0, pending},   {31'd0, m_has_q});
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_has_q});
   endtask

   initial begin
      int rd;
      // reset state
      step(1, 0, 0, 0);
      step(1, 1, 1, 9);
      // P=4 from idle; clk_div period 8
      step(0, 0, 1, 3);
      repeat (20) step(0, 1, 0, 0);
      // P=1 continuous tick
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      repeat (10) step(0, 1, 0, 0);
      // ratio change at cnt=1 in a P=4 run
      step(0, 0, 1, 3);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      repeat (12) step(0, 1, 0, 0);
      // config accepted on the wrap edge
      step(0, 0, 1, 3);
      step(0, 1, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      repeat (12) step(0, 1, 0, 0);
      // stop while pending, restart at queued ratio
      step(0, 0, 1, 3);
      step(0, 1, 0, 0);
      step(0, 1, 1, 2);
      step(0, 1, 1, 6);
      step(0, 0, 0, 0);
      repeat (10) step(0, 1, 0, 0);
      // reset mid-period while pending, restart at P=1
      step(0, 0, 1, 5);
      step(0, 1, 0, 0);
      step(0, 1, 1, 2);
      step(0, 1, 0, 0);
      step(1, 1, 1, 4);
      repeat (6) step(0, 1, 0, 0);
      // largest ratio: one full 256-cycle period
      step(0, 0, 1, 255);
      repeat (260) step(0, 1, 0, 0);
      // randomized
      for (int i = 0; i < 4000; i++) begin
         rd = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 39) != 0,
              $urandom_range(0, 7) == 0,
              rd);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
